// File: rtl/lfsr_gen_pkg.sv
// Shared types and default polynomial constants for the lfsr_gen pattern generator.
package lfsr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FREE  = 2'd2
  } fsm_e;

  localparam int unsigned DEF_WIDTH = 14;
  localparam int unsigned DEF_CNT_W = 16;

  // Fibonacci tap masks: bit k set means term x^(k+1); x^0 is implicit.
  localparam logic [7:0]  TAPS_W8  = 8'hB8;     // x^8+x^6+x^5+x^4+1
  localparam logic [7:0]  SEED_W8  = 8'h01;
  localparam logic [13:0] TAPS_W14 = 14'h3802;  // x^14+x^13+x^12+x^2+1
  localparam logic [13:0] SEED_W14 = 14'h0001;
  localparam logic [15:0] TAPS_W16 = 16'hB400;  // x^16+x^14+x^13+x^11+1
  localparam logic [15:0] SEED_W16 = 16'h0001;

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/status bundle between the pattern-path controller and lfsr_gen.
interface lfsr_gen_if
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             ena;
  logic             galois;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic             free_run;
  logic [WIDTH-1:0] state_out;
  logic             bit_out;
  logic             busy;
  logic             done;
  logic             wrap;
  logic             lockup;
  logic [WIDTH-1:0] period_out;

  modport master (
    output ena, galois, seed_load, seed_in, start, burst_len, free_run,
    input  state_out, bit_out, busy, done, wrap, lockup, period_out
  );

  modport slave (
    input  ena, galois, seed_load, seed_in, start, burst_len, free_run,
    output state_out, bit_out, busy, done, wrap, lockup, period_out
  );
endinterface

// File: rtl/lfsr_gen_step.sv
// Combinational LFSR next-state for Fibonacci and Galois forms of one polynomial.
module lfsr_gen_step
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W14)
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             galois,
  output logic [WIDTH-1:0] next_c
);

  // Galois form of the same polynomial: taps shifted up with the x^0 term in bit 0.
  localparam logic [WIDTH-1:0] GTAPS = {TAPS[WIDTH-2:0], 1'b1};

  logic fb_c;

  always_comb begin
    fb_c = ^(cur & TAPS);
    if (galois) begin
      next_c = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? GTAPS : '0);
    end else begin
      next_c = {cur[WIDTH-2:0], fb_c};
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR pattern generator with seed load, counted bursts and wrap detection.
// Define LFSR_GEN_PERIOD_MEAS_EN to build the wrap-to-wrap period counter.
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W14),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_W14),
  parameter int unsigned      CNT_W = DEF_CNT_W
) (
  input  logic     clk,
  input  logic     rst_n,
  lfsr_gen_if.slave bus
);

  fsm_e             fsm_q, fsm_n;
  logic [WIDTH-1:0] state_q, state_n;
  logic [WIDTH-1:0] ref_q, ref_n;
  logic [CNT_W-1:0] rem_q, rem_n;
  logic             busy_q, done_q, done_n, wrap_q, wrap_n, lockup_q, lockup_n;
  logic [WIDTH-1:0] next_c;
  logic             step_c;

  lfsr_gen_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
    .cur    (state_q),
    .galois (bus.galois),
    .next_c (next_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= ST_IDLE;
      state_q  <= SEED;
      ref_q    <= SEED;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_n;
      state_q  <= state_n;
      ref_q    <= ref_n;
      rem_q    <= rem_n;
      busy_q   <= (fsm_n != ST_IDLE);
      done_q   <= done_n;
      wrap_q   <= wrap_n;
      lockup_q <= lockup_n;
    end
  end

  // seed_load outranks everything, including ena; a zero seed falls back to SEED.
  always_comb begin
    fsm_n    = fsm_q;
    state_n  = state_q;
    ref_n    = ref_q;
    rem_n    = rem_q;
    lockup_n = lockup_q;
    done_n   = 1'b0;
    wrap_n   = 1'b0;
    step_c   = 1'b0;
    if (bus.seed_load) begin
      fsm_n = ST_IDLE;
      rem_n = '0;
      if (bus.seed_in != '0) begin
        state_n  = bus.seed_in;
        ref_n    = bus.seed_in;
        lockup_n = 1'b0;
      end else begin
        state_n  = SEED;
        ref_n    = SEED;
        lockup_n = 1'b1;
      end
    end else if (bus.ena) begin
      unique case (fsm_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.burst_len == '0) begin
              done_n = 1'b1;
            end else begin
              fsm_n = ST_BURST;
              rem_n = bus.burst_len;
            end
          end else if (bus.free_run) begin
            fsm_n = ST_FREE;
          end
        end
        ST_BURST: begin
          step_c = 1'b1;
          rem_n  = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            fsm_n  = ST_IDLE;
            done_n = 1'b1;
          end
        end
        ST_FREE: begin
          if (bus.free_run) step_c = 1'b1;
          else              fsm_n  = ST_IDLE;
        end
        default: fsm_n = ST_IDLE;
      endcase
      if (step_c) begin
        state_n = next_c;
        wrap_n  = (next_c == ref_q);
      end
    end
  end

`ifdef LFSR_GEN_PERIOD_MEAS_EN
  logic [WIDTH-1:0] cnt_q, cnt_n, period_q, period_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_n;
      period_q <= period_n;
    end
  end

  // Steps since the last wrap/load; both the count and the reported period saturate.
  always_comb begin
    cnt_n    = cnt_q;
    period_n = period_q;
    if (bus.seed_load) begin
      cnt_n = '0;
    end else if (step_c) begin
      if (wrap_n) begin
        period_n = (&cnt_q) ? cnt_q : cnt_q + WIDTH'(1);
        cnt_n    = '0;
      end else if (!(&cnt_q)) begin
        cnt_n = cnt_q + WIDTH'(1);
      end
    end
  end

  assign bus.period_out = period_q;
`else
  assign bus.period_out = '0;
`endif

  assign bus.state_out = state_q;
  assign bus.bit_out   = state_q[WIDTH-1];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;
  assign bus.lockup    = lockup_q;

endmodule
